// File: rtl/tlc_pkg.sv
// Shared lamp encodings, FSM state type and a small helper for the N-way
// intersection controller.
package tlc_pkg;

    localparam logic [1:0] LITE_RED    = 2'b00;
    localparam logic [1:0] LITE_YELLOW = 2'b01;
    localparam logic [1:0] LITE_GREEN  = 2'b10;

    typedef enum logic [1:0] {
        ALL_RED = 2'd0,
        GREEN   = 2'd1,
        YELLOW  = 2'd2
    } tlc_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tlc_if.sv
// Sensor/lamp bundle between the intersection controller (master) and its
// surroundings (slave). Optional TLC_PREEMPT_EN adds the preemption request pair.
interface tlc_if #(
    parameter int N_WAYS = 4,
    parameter int WW     = $clog2(N_WAYS)
);
    logic [N_WAYS-1:0]   car;
    logic [2*N_WAYS-1:0] lite;
    logic [WW-1:0]       green_way;
    logic [N_WAYS-1:0]   pending;
`ifdef TLC_PREEMPT_EN
    logic                preempt_req;
    logic [WW-1:0]       preempt_way;
`endif

    modport master (
        output lite, green_way, pending,
`ifdef TLC_PREEMPT_EN
        input  preempt_req, preempt_way,
`endif
        input  car
    );

    modport slave (
        input  lite, green_way, pending,
`ifdef TLC_PREEMPT_EN
        output preempt_req, preempt_way,
`endif
        output car
    );
endinterface

// File: rtl/tlc_rr_arbiter.sv
// Combinational round-robin picker: first requesting way strictly after
// 'last', wrapping around so 'last' itself is considered last of all.
module tlc_rr_arbiter #(
    parameter  int N_WAYS = 4,
    localparam int WW     = $clog2(N_WAYS)
) (
    input  logic [N_WAYS-1:0] req,
    input  logic [WW-1:0]     last,
    output logic [WW-1:0]     grant,
    output logic              any_req
);
    logic          found;
    logic [WW-1:0] idx;

    always_comb begin
        grant = last;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N_WAYS; k++) begin
            idx = WW'((int'(last) + k) % N_WAYS);
            if (!found && req[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    assign any_req = |req;
endmodule

// File: rtl/traffic_light_controller_nway.sv
// N-way intersection controller: latched requests, round-robin service, min/max
// green, yellow and all-red clearance. Optional macro TLC_PREEMPT_EN adds preemption.
module traffic_light_controller_nway
    import tlc_pkg::*;
#(
    parameter int N_WAYS     = 4,
    parameter int MIN_GREEN  = 4,
    parameter int MAX_GREEN  = 8,
    parameter int YELLOW_CYC = 2,
    parameter int CLEAR_CYC  = 1
) (
    input logic  clock,
    input logic  reset_n,
    tlc_if.master bus
);
    localparam int WW   = $clog2(N_WAYS);
    localparam int TMAX = max3(MAX_GREEN, YELLOW_CYC, CLEAR_CYC);
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] T_MIN = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] T_MAX = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] T_YEL = TW'(YELLOW_CYC - 1);
    localparam logic [TW-1:0] T_CLR = TW'(CLEAR_CYC - 1);
    localparam logic [TW-1:0] T_SAT = TW'(TMAX - 1);

    if (N_WAYS < 2 || N_WAYS > 8) begin : g_bad_ways
        $error("N_WAYS must be in 2..8");
    end
    if (MIN_GREEN < 1 || MAX_GREEN < MIN_GREEN) begin : g_bad_green
        $error("need 1 <= MIN_GREEN <= MAX_GREEN");
    end
    if (YELLOW_CYC < 1 || CLEAR_CYC < 1) begin : g_bad_clear
        $error("YELLOW_CYC and CLEAR_CYC must be >= 1");
    end

    tlc_state_e          state, state_nxt;
    logic [TW-1:0]       timer;
    logic [WW-1:0]       gw, gw_nxt, sel_way, arb_grant;
    logic [N_WAYS-1:0]   car, pending, pend_nxt, green_mask;
    logic [2*N_WAYS-1:0] lite;
    logic                arb_any, enter_green, pre_go, pre_hold;

    assign car = bus.car;

    tlc_rr_arbiter #(.N_WAYS(N_WAYS)) u_arb (
        .req     (pending),
        .last    (gw),
        .grant   (arb_grant),
        .any_req (arb_any)
    );

`ifdef TLC_PREEMPT_EN
    logic          pre_lat;
    logic [WW-1:0] pre_way;

    assign pre_go   = bus.preempt_req && (bus.preempt_way != gw);
    assign pre_hold = bus.preempt_req && (bus.preempt_way == gw);
    // A preemption that drops during YELLOW still owns the next green.
    assign sel_way  = bus.preempt_req ? bus.preempt_way :
                      pre_lat         ? pre_way         :
                      arb_any         ? arb_grant       : gw;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre_lat <= 1'b0;
            pre_way <= '0;
        end else if (state == GREEN && pre_go) begin
            pre_lat <= 1'b1;
            pre_way <= bus.preempt_way;
        end else if (enter_green) begin
            pre_lat <= 1'b0;
        end
    end
`else
    assign pre_go   = 1'b0;
    assign pre_hold = 1'b0;
    assign sel_way  = arb_any ? arb_grant : gw;
`endif

    always_comb begin
        green_mask = '0;
        if (state == GREEN) green_mask[gw] = 1'b1;
    end

    // State register (plus timer, served way and request latch)
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ALL_RED;
            timer   <= '0;
            gw      <= '0;
            pending <= '0;
        end else begin
            state   <= state_nxt;
            gw      <= gw_nxt;
            pending <= pend_nxt;
            if (state_nxt != state)  timer <= '0;
            else if (timer != T_SAT) timer <= timer + 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        gw_nxt    = gw;
        case (state)
            ALL_RED: if (timer == T_CLR) begin
                state_nxt = GREEN;
                gw_nxt    = sel_way;
            end
            GREEN: begin
                if (pre_go)
                    state_nxt = YELLOW;
                else if (!pre_hold && |(pending & ~green_mask) && timer >= T_MIN &&
                         (!car[gw] || timer >= T_MAX))
                    state_nxt = YELLOW;
            end
            YELLOW: if (timer == T_YEL) state_nxt = ALL_RED;
            default: state_nxt = ALL_RED;
        endcase
    end

    assign enter_green = (state == ALL_RED) && (state_nxt == GREEN);

    always_comb begin
        pend_nxt = pending | (car & ~green_mask);
        if (enter_green) pend_nxt[gw_nxt] = 1'b0;
    end

    // Output decode from registered state only
    always_comb begin
        lite = '0;
        for (int i = 0; i < N_WAYS; i++) begin
            if (WW'(i) == gw) begin
                case (state)
                    GREEN:   lite[2*i +: 2] = LITE_GREEN;
                    YELLOW:  lite[2*i +: 2] = LITE_YELLOW;
                    default: lite[2*i +: 2] = LITE_RED;
                endcase
            end
        end
    end

    assign bus.lite      = lite;
    assign bus.green_way = gw;
    assign bus.pending   = pending;
endmodule
